// File: rtl/pcm_i2s_tx_if.sv
// Parallel PCM bus from the pcmplay core: fs strobe, stereo sample pair and mute level.
// The producer owns every signal; the I2S transmitter only listens.
interface pcm_i2s_tx_if;
  logic        pcm_fs;
  logic [15:0] pcm_ldata;
  logic [15:0] pcm_rdata;
  logic        pcm_mute;

  modport master (output pcm_fs, output pcm_ldata, output pcm_rdata, output pcm_mute);
  modport slave  (input  pcm_fs, input  pcm_ldata, input  pcm_rdata, input  pcm_mute);
endinterface

// File: rtl/pcm_i2s_tx.sv
// PCM-to-I2S transmitter on the 128fs clock: captures a stereo sample per fs edge,
// serializes it at BCLK=64fs, tracks fs phase lock and repeats samples on underrun.
module pcm_i2s_tx #(
  parameter int JUSTIFY    = 0,
  parameter int MISS_LIMIT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  pcm_i2s_tx_if.slave pcm,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata,
  output logic        locked,
  output logic        underrun
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  localparam logic [3:0] LP_MISS_LIMIT = 4'(MISS_LIMIT);
  localparam logic [4:0] LP_FIRST_K    = (JUSTIFY != 0) ? 5'd0 : 5'd1;

  state_t      r_state;
  state_t      w_next_state;
  logic [6:0]  r_cnt;
  logic        r_fs_d;
  logic [15:0] r_active_l;
  logic [15:0] r_active_r;
  logic [15:0] r_hold_l;
  logic [15:0] r_hold_r;
  logic        r_pend;
  logic [3:0]  r_miss_cnt;
  logic        r_bclk;
  logic        r_lrck;
  logic        r_sdata;

  logic        w_edge;
  logic        w_boundary;
  logic        w_locked;
  logic        w_underrun;
  logic        w_phase_err;
  logic [3:0]  w_miss_next;
  logic        w_miss_drop;
  logic [15:0] w_load_l;
  logic [15:0] w_load_r;
  logic [4:0]  w_k;
  logic [4:0]  w_pos;
  logic [15:0] w_word;
  logic        w_sdata_next;

  assign w_edge      = pcm.pcm_fs & ~r_fs_d;
  assign w_boundary  = (r_cnt == 7'd127);
  assign w_phase_err = w_locked & w_edge & ~w_boundary;
  assign w_miss_next = r_miss_cnt + 4'd1;
  assign w_miss_drop = w_underrun & (w_miss_next == LP_MISS_LIMIT);

  // Fresh edge data wins over the held sample; mute is applied only at load time
  // so a word already on the wire is never cut mid-way.
  assign w_load_l = pcm.pcm_mute ? 16'd0 : (w_edge ? pcm.pcm_ldata : r_hold_l);
  assign w_load_r = pcm.pcm_mute ? 16'd0 : (w_edge ? pcm.pcm_rdata : r_hold_r);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_UNLOCKED;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_UNLOCKED: if (w_edge) w_next_state = ST_LOCKED;
      ST_LOCKED:   if (w_phase_err || w_miss_drop) w_next_state = ST_UNLOCKED;
    endcase
  end

  always_comb begin
    w_locked   = 1'b0;
    w_underrun = 1'b0;
    case (r_state)
      ST_UNLOCKED: begin
        w_locked   = 1'b0;
        w_underrun = 1'b0;
      end
      ST_LOCKED: begin
        w_locked   = 1'b1;
        w_underrun = w_boundary & ~w_edge & ~r_pend;
      end
    endcase
  end

  // Bit position inside the current half-frame; out-of-word slots pad with zero.
  assign w_k          = r_cnt[5:1];
  assign w_pos        = w_k - LP_FIRST_K;
  assign w_word       = r_cnt[6] ? r_active_r : r_active_l;
  assign w_sdata_next = w_locked & (w_pos < 5'd16) & w_word[4'd15 - w_pos[3:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt      <= 7'd0;
      r_fs_d     <= 1'b0;
      r_active_l <= 16'd0;
      r_active_r <= 16'd0;
      r_hold_l   <= 16'd0;
      r_hold_r   <= 16'd0;
      r_pend     <= 1'b0;
      r_miss_cnt <= 4'd0;
      r_bclk     <= 1'b0;
      r_lrck     <= 1'b0;
      r_sdata    <= 1'b0;
    end else begin
      r_fs_d  <= pcm.pcm_fs;
      r_cnt   <= r_cnt + 7'd1;
      r_bclk  <= r_cnt[0];
      r_lrck  <= r_cnt[6];
      r_sdata <= w_sdata_next;
      if (!w_locked) begin
        // Any edge while unlocked realigns the frame; a stale pending sample is dropped.
        if (w_edge) begin
          r_cnt      <= 7'd0;
          r_active_l <= w_load_l;
          r_active_r <= w_load_r;
          r_miss_cnt <= 4'd0;
          r_pend     <= 1'b0;
        end
      end else begin
        if (w_edge) begin
          r_hold_l <= pcm.pcm_ldata;
          r_hold_r <= pcm.pcm_rdata;
          r_pend   <= 1'b1;
        end
        if (w_boundary) begin
          if (w_edge || r_pend) begin
            r_active_l <= w_load_l;
            r_active_r <= w_load_r;
            r_pend     <= 1'b0;
            r_miss_cnt <= 4'd0;
          end else begin
            r_miss_cnt <= w_miss_next;
          end
        end
      end
    end
  end

  assign i2s_bclk  = r_bclk;
  assign i2s_lrck  = r_lrck;
  assign i2s_sdata = r_sdata;
  assign locked    = w_locked;
  assign underrun  = w_underrun;

endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Bench for pcm_i2s_tx: one DUT per serial format fed from a shared PCM bus,
// checked frame by frame against a sample-level model of lock, repeat and mute.
module tb_pcm_i2s_tx;
  localparam int MISS_LIMIT = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pcm_i2s_tx_if pcm_bus ();

  logic bclk0, lrck0, sdata0, locked0, underrun0;
  logic bclk1, lrck1, sdata1, locked1, underrun1;

  pcm_i2s_tx #(.JUSTIFY(0), .MISS_LIMIT(MISS_LIMIT)) dut0 (
    .clk(clk), .reset_n(reset_n), .pcm(pcm_bus),
    .i2s_bclk(bclk0), .i2s_lrck(lrck0), .i2s_sdata(sdata0),
    .locked(locked0), .underrun(underrun0)
  );

  pcm_i2s_tx #(.JUSTIFY(1), .MISS_LIMIT(MISS_LIMIT)) dut1 (
    .clk(clk), .reset_n(reset_n), .pcm(pcm_bus),
    .i2s_bclk(bclk1), .i2s_lrck(lrck1), .i2s_sdata(sdata1),
    .locked(locked1), .underrun(underrun1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];

  // Sample-level model: what each frame should play, and whether fs lock is held.
  bit          m_locked = 1'b0;
  logic [15:0] m_l = 16'd0;
  logic [15:0] m_r = 16'd0;
  int          m_miss = 0;
  bit          cur_mute = 1'b0;
  int          fs_hi_left = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input bit left_just, input logic [15:0] s);
    return left_just ? {s, 16'd0} : {1'b0, s, 15'd0};
  endfunction

  function automatic logic [15:0] rnd16();
    return 16'($urandom());
  endfunction

  // One clock: drive inputs after the falling edge, then let outputs settle for sampling.
  task automatic step(input bit fs_edge, input logic [15:0] l, input logic [15:0] r,
                      input bit mute, input bit rst_n);
    @(negedge clk);
    if (fs_edge) fs_hi_left = $urandom_range(1, 40);
    pcm_bus.pcm_fs    = (fs_hi_left > 0);
    if (fs_hi_left > 0) fs_hi_left--;
    pcm_bus.pcm_ldata = l;
    pcm_bus.pcm_rdata = r;
    pcm_bus.pcm_mute  = mute;
    reset_n           = rst_n;
    #1;
  endtask

  task automatic idle(input int n);
    while (fs_hi_left > 0) step(1'b0, rnd16(), rnd16(), cur_mute, 1'b1);
    repeat (n) step(1'b0, rnd16(), rnd16(), cur_mute, 1'b1);
    check("idle_locked_j0", 32'(locked0), 32'(m_locked));
    check("idle_locked_j1", 32'(locked1), 32'(m_locked));
  endtask

  task automatic lock_edge(input logic [15:0] l, input logic [15:0] r);
    step(1'b1, l, r, cur_mute, 1'b1);
    m_locked = 1'b1;
    m_miss   = 0;
    m_l      = cur_mute ? 16'd0 : l;
    m_r      = cur_mute ? 16'd0 : r;
    step(1'b0, rnd16(), rnd16(), cur_mute, 1'b1);
    check("lock_j0", 32'(locked0), 32'd1);
    check("lock_j1", 32'(locked1), 32'd1);
  endtask

  // mode 0: nominal edge at the frame boundary, 1: edge omitted,
  // 2: stray edge at cnt==40, 3: one-cycle reset mid-frame.
  task automatic run_frame(input int mode, input logic [15:0] nl, input logic [15:0] nr,
                           input int flip_i, input bit mute_to);
    logic [31:0] w0 [2];
    logic [31:0] w1 [2];
    logic [15:0] el, er;
    int  clk_err, ur0, ur1, rst_i, k, h;
    bit  ur0_126, ur1_126, mute_now, mute_load, edge_now, exp_ur;
    exp_q.push_back(m_locked ? m_l : 16'd0);
    exp_q.push_back((m_locked && mode != 2) ? m_r : 16'd0);
    exp_ur    = m_locked && (mode == 1);
    clk_err   = 0;
    ur0       = 0;
    ur1       = 0;
    ur0_126   = 1'b0;
    ur1_126   = 1'b0;
    mute_now  = cur_mute;
    mute_load = cur_mute;
    rst_i     = $urandom_range(64, 120);
    for (int j = 0; j < 2; j++) begin
      w0[j] = 32'd0;
      w1[j] = 32'd0;
    end
    for (int i = 0; i < 128; i++) begin
      mute_now = (i >= flip_i) ? mute_to : cur_mute;
      edge_now = (mode == 0 && i == 126) || (mode == 2 && i == 39);
      if (mode == 3 && i == rst_i) begin
        step(1'b0, rnd16(), rnd16(), mute_now, 1'b0);
        step(1'b0, rnd16(), rnd16(), mute_now, 1'b1);
        check("rst_outs_j0", 32'({bclk0, lrck0, sdata0, locked0, underrun0}), 32'd0);
        check("rst_outs_j1", 32'({bclk1, lrck1, sdata1, locked1, underrun1}), 32'd0);
        m_locked = 1'b0;
        m_l      = 16'd0;
        m_r      = 16'd0;
        m_miss   = 0;
        cur_mute = mute_now;
        exp_q.delete();
        return;
      end
      step(edge_now, edge_now ? nl : rnd16(), edge_now ? nr : rnd16(), mute_now, 1'b1);
      if (i == 126) mute_load = mute_now;
      if (i == 0) begin
        check("frame_locked_j0", 32'(locked0), 32'(m_locked));
        check("frame_locked_j1", 32'(locked1), 32'(m_locked));
      end
      if (mode == 2 && i == 40) begin
        check("perr_locked_j0", 32'(locked0), 32'd0);
        check("perr_locked_j1", 32'(locked1), 32'd0);
      end
      if (bclk0 !== 1'(i % 2) || bclk1 !== 1'(i % 2)) clk_err++;
      if (lrck0 !== 1'(i / 64) || lrck1 !== 1'(i / 64)) clk_err++;
      if (i % 2 == 1) begin
        k = (i / 2) % 32;
        h = i / 64;
        w0[h][31 - k] = sdata0;
        w1[h][31 - k] = sdata1;
      end
      ur0 += int'(underrun0);
      ur1 += int'(underrun1);
      if (i == 126) begin
        ur0_126 = underrun0;
        ur1_126 = underrun1;
      end
    end
    cur_mute = mute_now;
    el = exp_q.pop_front();
    er = exp_q.pop_front();
    check("clk_pattern", 32'(clk_err), 32'd0);
    check("word_l_j0", w0[0], fmt(1'b0, el));
    check("word_r_j0", w0[1], fmt(1'b0, er));
    check("word_l_j1", w1[0], fmt(1'b1, el));
    check("word_r_j1", w1[1], fmt(1'b1, er));
    check("underrun_j0", 32'(ur0 * 2 + int'(ur0_126)), exp_ur ? 32'd3 : 32'd0);
    check("underrun_j1", 32'(ur1 * 2 + int'(ur1_126)), exp_ur ? 32'd3 : 32'd0);
    case (mode)
      0: begin
        m_l    = mute_load ? 16'd0 : nl;
        m_r    = mute_load ? 16'd0 : nr;
        m_miss = 0;
      end
      1: if (m_locked) begin
        m_miss++;
        if (m_miss == MISS_LIMIT) m_locked = 1'b0;
      end
      2: m_locked = 1'b0;
      default: ;
    endcase
  endtask

  initial begin
    int sel, mode;
    pcm_bus.pcm_fs    = 1'b0;
    pcm_bus.pcm_ldata = 16'd0;
    pcm_bus.pcm_rdata = 16'd0;
    pcm_bus.pcm_mute  = 1'b0;
    reset_n           = 1'b0;

    repeat (3) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    check("reset_outs_j0", 32'({bclk0, lrck0, sdata0, locked0, underrun0}), 32'd0);
    check("reset_outs_j1", 32'({bclk1, lrck1, sdata1, locked1, underrun1}), 32'd0);

    idle($urandom_range(3, 40));
    lock_edge(16'hA5C3, 16'h0F0F);
    run_frame(0, 16'h8001, rnd16(), 128, 1'b0);
    run_frame(0, rnd16(), rnd16(), 128, 1'b0);
    run_frame(1, rnd16(), rnd16(), 128, 1'b0);
    run_frame(0, rnd16(), rnd16(), 128, 1'b0);

    run_frame(0, 16'h7FFF, rnd16(), 128, 1'b0);
    run_frame(0, 16'h7FFF, rnd16(), 60, 1'b1);
    run_frame(0, 16'h7FFF, rnd16(), 128, 1'b1);
    run_frame(0, 16'h7FFF, rnd16(), 50, 1'b0);
    run_frame(0, rnd16(), rnd16(), 128, 1'b0);

    run_frame(1, rnd16(), rnd16(), 128, 1'b0);
    run_frame(1, rnd16(), rnd16(), 128, 1'b0);
    run_frame(1, rnd16(), rnd16(), 128, 1'b0);

    idle($urandom_range(1, 50));
    lock_edge(rnd16(), rnd16());
    run_frame(0, rnd16(), rnd16(), 128, 1'b0);
    run_frame(2, rnd16(), rnd16(), 128, 1'b0);
    idle($urandom_range(1, 90));
    lock_edge(rnd16(), rnd16());
    run_frame(0, rnd16(), rnd16(), 128, 1'b0);
    run_frame(3, rnd16(), rnd16(), 128, 1'b0);
    idle($urandom_range(5, 30));
    lock_edge(rnd16(), rnd16());

    for (int f = 0; f < 30; f++) begin
      if (!m_locked) begin
        idle($urandom_range(1, 50));
        lock_edge(rnd16(), rnd16());
      end
      sel  = $urandom_range(0, 9);
      mode = (sel < 7) ? 0 : (sel < 9) ? 1 : 2;
      run_frame(mode, rnd16(), rnd16(), $urandom_range(0, 140), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
